// File: rtl/booth_pkg.sv
// booth_pkg: shared state, recode-digit and iteration-count definitions for the radix-4 Booth multiplier
package booth_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic neg;
        logic two;
        logic nz;
    } sel_t;
    function automatic int n_iter(input int width);
        return width / 2 + 1;
    endfunction
    function automatic sel_t recode(input logic [2:0] q);
        return '{neg: q[2] && !(q[1] && q[0]), two: q == 3'b011 || q == 3'b100, nz: q != 3'b000 && q != 3'b111};
    endfunction
endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode: turns a Booth bit triple and multiplicand into a sign-extended partial product
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = 192
) (
    input  logic [2:0]       q,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+3:0] pp
);
    sel_t sel;
    logic [WIDTH+3:0] mag;
    // select 0, M or 2M, then negate for the negative digits
    always_comb begin
        sel = recode(q);
        mag = !sel.nz ? '0 : sel.two ? {m[WIDTH+1], m, 1'b0} : {{2{m[WIDTH+1]}}, m};
        pp = sel.neg ? -mag : mag;
    end
endmodule

// File: rtl/booth_r4_seq.sv
// booth_r4_seq: iterative radix-4 Booth multiplier, two multiplier bits retired per cycle
module booth_r4_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 192
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);
    localparam int N_ITER = n_iter(WIDTH);
    localparam int CW = $clog2(N_ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);
    state_t state, state_n;
    logic [WIDTH+1:0] m;
    logic [WIDTH+2:0] q;
    logic [WIDTH+3:0] p, pp, sum;
    logic [2*WIDTH+6:0] shifted;
    logic [CW-1:0] cnt;
    logic accept, last;
    booth_r4_recode #(.WIDTH(WIDTH)) u_recode (.q(q[2:0]), .m(m), .pp(pp));
    assign busy = state == RUN;
    // next state plus the accumulate-and-shift step for the current digit
    always_comb begin
        accept = state == IDLE && start;
        last = state == RUN && cnt == '0;
        state_n = accept ? RUN : last ? IDLE : state;
        sum = p + pp;
        shifted = $signed({sum, q}) >>> 2;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // operand capture, iteration datapath and result register; the extra extended digit makes unsigned exact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            q <= '0;
            p <= '0;
            cnt <= '0;
            c <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                m <= {{2{signed_mode & a[WIDTH-1]}}, a};
                q <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                p <= '0;
                cnt <= CNT_LAST;
            end else if (state == RUN) begin
                {p, q} <= shifted;
                cnt <= cnt - 1'b1;
                if (last) c <= shifted[2*WIDTH:1];
            end
        end
    end
endmodule

// File: tb/tb_booth_r4_seq.sv
// tb_booth_r4_seq: scoreboard bench running 8, 64 and 192-bit multipliers against an arithmetic reference
module tb_booth_r4_seq;
    localparam int NW = 3;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, sm = 1'b0;
    logic [191:0] a = '0, b = '0;
    logic [15:0] c8;
    logic [127:0] c64;
    logic [383:0] c192;
    logic [383:0] c_w [NW];
    logic busy_w [NW], done_w [NW];
    logic exp_done [NW];
    logic [383:0] model_c [NW];
    int mcnt [NW];
    logic [383:0] q0 [$], q1 [$], q2 [$];
    int total = 0, bad = 0;
    logic finishing = 1'b0, end_checked = 1'b0;

    booth_r4_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a[7:0]), .b(b[7:0]),
        .busy(busy_w[0]), .done(done_w[0]), .c(c8));
    booth_r4_seq #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a[63:0]), .b(b[63:0]),
        .busy(busy_w[1]), .done(done_w[1]), .c(c64));
    booth_r4_seq #(.WIDTH(192)) u192 (.clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy_w[2]), .done(done_w[2]), .c(c192));
    assign c_w[0] = {368'b0, c8};
    assign c_w[1] = {256'b0, c64};
    assign c_w[2] = c192;

    always #5 clk = ~clk;

    function automatic int wd(input int i);
        return i == 0 ? 8 : i == 1 ? 64 : 192;
    endfunction

    function automatic logic [383:0] ref_mul(input int w, input logic s, input logic [191:0] x, input logic [191:0] y);
        logic [383:0] mask, ex, ey, pr;
        mask = (384'd1 << w) - 384'd1;
        ex = {192'b0, x} & mask;
        ey = {192'b0, y} & mask;
        if (s && ex[w-1]) ex = ex | ~mask;
        if (s && ey[w-1]) ey = ey | ~mask;
        pr = ex * ey;
        return pr & ((384'd1 << (2 * w)) - 384'd1);
    endfunction

    function automatic logic [191:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int qsize(input int i);
        return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    endfunction

    function automatic logic [383:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        if (i == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    task automatic chk(input string nm, input int i, input logic [383:0] got, input logic [383:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s w=%0d got=%h exp=%h", nm, wd(i), got, exp);
        end
    endtask

    // reference timing model: accepts start when idle, pushes the expected product, counts down the run
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NW; i++) begin
            exp_done[i] = !rst && mcnt[i] == 1;
            if (rst) mcnt[i] = 0;
            else if (mcnt[i] == 0 && start) begin
                mcnt[i] = wd(i) / 2 + 1;
                if (i == 0) q0.push_back(ref_mul(wd(i), sm, a, b));
                else if (i == 1) q1.push_back(ref_mul(wd(i), sm, a, b));
                else q2.push_back(ref_mul(wd(i), sm, a, b));
            end else if (mcnt[i] != 0) mcnt[i]--;
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
    end

    // monitor: checks handshake timing each cycle, pops the scoreboard on every done, checks c holds
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            #1;
            for (int i = 0; i < NW; i++) begin
                chk("rst_busy", i, 384'(busy_w[i]), 384'd0);
                chk("rst_done", i, 384'(done_w[i]), 384'd0);
                chk("rst_c", i, c_w[i], 384'd0);
                model_c[i] = '0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                chk("busy", i, 384'(busy_w[i]), 384'(mcnt[i] != 0));
                chk("done", i, 384'(done_w[i]), 384'(exp_done[i]));
                if (done_w[i]) begin
                    chk("done_has_entry", i, 384'(qsize(i) != 0), 384'd1);
                    if (qsize(i) != 0) model_c[i] = qpop(i);
                end
                chk("c", i, c_w[i], model_c[i]);
            end
            if (finishing && !end_checked) begin
                for (int i = 0; i < NW; i++) chk("drain", i, 384'(qsize(i)), 384'd0);
                end_checked = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 400 && (mcnt[0] != 0 || mcnt[1] != 0 || mcnt[2] != 0); k++) @(negedge clk);
    endtask

    task automatic op(input logic s, input logic [191:0] x, input logic [191:0] y);
        wait_idle();
        @(negedge clk);
        #1;
        sm = s;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        sm = ~s;
        a = rnd();
        b = rnd();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        op(1'b1, 192'hFD, 192'h05);
        op(1'b0, '1, '1);
        op(1'b1, '1, '1);
        op(1'b1, 192'h80, 192'h80);
        op(1'b0, 192'h80, 192'h80);
        op(1'b0, 192'hFF, 192'h80);
        op(1'b1, '1, {1'b0, {191{1'b1}}});
        op(1'b1, rnd(), rnd());
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        op(1'b0, rnd(), rnd());
        op(1'b1, rnd(), rnd());
        wait_idle();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            start = 1'b1;
            sm = 1'($urandom);
            a = rnd();
            b = rnd();
        end
        @(negedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        finishing = 1'b1;
        for (int k = 0; k < 10 && !end_checked; k++) @(negedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
